// File: rtl/mult_operand_sequencer.sv
// Operand FIFO and job sequencer in front of a start/done sequential multiplier.
// Jobs are run one at a time under a watchdog; each outcome lands in a single result slot.
module mult_operand_sequencer #(
    parameter int WIDTH       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_start,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_m,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [2*WIDTH-1:0] out_m,
    output logic               out_err,
    output logic               busy
);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [WIDTH-1:0]   fifo_a_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_b_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [1:0]         state_q, state_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic               mul_start_q, mul_start_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic [2*WIDTH-1:0] out_m_q, out_m_d;
    logic               out_err_q, out_err_d;
    logic               push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = mul_start_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_m_d     = out_m_q;
        out_err_d   = out_err_q;
        pop         = 1'b0;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            // Launch waits for an empty result slot, even if it is being accepted now.
            IDLE: begin
                if (!fifo_empty && !out_valid_q) begin
                    pop         = 1'b1;
                    mul_a_d     = fifo_a_q[rd_ptr_q];
                    mul_b_d     = fifo_b_q[rd_ptr_q];
                    mul_start_d = 1'b1;
                    wd_d        = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                wd_d = wd_q + 1'b1;
                if (mul_done) begin
                    out_m_d     = mul_m;
                    out_a_d     = mul_a_q;
                    out_b_d     = mul_b_q;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    mul_start_d = 1'b0;
                    state_d     = DRAIN;
                end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
                    out_m_d     = '0;
                    out_a_d     = mul_a_q;
                    out_b_d     = mul_b_q;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    mul_start_d = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (!mul_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage has no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= in_a;
            fifo_b_q[wr_ptr_q] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            wd_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_m_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
            state_q     <= state_d;
            wd_q        <= wd_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_m_q     <= out_m_d;
            out_err_q   <= out_err_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_start = mul_start_q;
    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_m     = out_m_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
